cache_req_queue: RTL and testbench

Request queue and sequencer sitting directly upstream of the direct-mapped cache top (`main`). Accepts CPU load/store requests through a valid/ready handshake, buffers up to DEPTH of them, and issues them one at a time on the cache's `valid_req`/`rw`/`addr`/`dataIn` port, pacing on `cache_ready`. Captures `dataOut` and the hit/miss outcome of each request, returns an in-order response pulse, and keeps hit/miss statistics.

---
 rtl/cache_req_queue_if.sv | 46 ++++
 rtl/cache_req_queue.sv | 198 +++++++++++++++++++
 tb/tb_cache_req_queue.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_req_queue_if.sv
// Bundle of the CPU request, cache issue and response/statistics signals
// around cache_req_queue. The queue uses the slave view; the requester /
// cache side (or a bench) uses the master view.
interface cache_req_queue_if #(
    parameter int CNT_W = 16
);
    // CPU request channel
    logic             cpu_valid;
    logic             cpu_ready;
    logic             cpu_rw;
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    // Cache issue port
    logic             valid_req;
    logic             rw;
    logic [31:0]      addr;
    logic [31:0]      dataIn;
    logic             cache_ready;
    logic             hit;
    logic             miss;
    logic [31:0]      dataOut;
    // In-order response and statistics
    logic             rsp_valid;
    logic             rsp_rw;
    logic [31:0]      rsp_data;
    logic             rsp_hit;
    logic             rsp_err;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport slave (
        input  cpu_valid, cpu_rw, cpu_addr, cpu_wdata,
        input  cache_ready, hit, miss, dataOut,
        output cpu_ready, valid_req, rw, addr, dataIn,
        output rsp_valid, rsp_rw, rsp_data, rsp_hit, rsp_err,
        output hit_count, miss_count
    );

    modport master (
        output cpu_valid, cpu_rw, cpu_addr, cpu_wdata,
        output cache_ready, hit, miss, dataOut,
        input  cpu_ready, valid_req, rw, addr, dataIn,
        input  rsp_valid, rsp_rw, rsp_data, rsp_hit, rsp_err,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/cache_req_queue.sv
// Request queue and sequencer in front of the direct-mapped cache.
// Buffers up to DEPTH CPU requests, issues them one at a time to the cache,
// tracks hit/miss per request, returns in-order response pulses and keeps
// saturating hit/miss statistics.
//
// Handshake: a CPU request transfers on a rising edge where cpu_valid and
// cpu_ready are both 1; cpu_ready depends only on queue fullness (and reset),
// never on cpu_valid. Toward the cache, valid_req is a one-cycle strobe; the
// cache acknowledges by dropping cache_ready and completes by raising it.
// Responses have no backpressure: rsp_valid is a one-cycle pulse.
module cache_req_queue #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    cache_req_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              fifo_rw    [DEPTH];
    logic [31:0]       fifo_addr  [DEPTH];
    logic [31:0]       fifo_wdata [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic [TW-1:0]     ack_timer;
    logic              timeout;
    logic              hit_seen;
    logic              miss_seen;

    logic              rsp_rw_q;
    logic [31:0]       rsp_data_q;
    logic              rsp_hit_q;
    logic              rsp_err_q;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    logic              head_rw;
    logic              done_now;
    logic              abandon_now;

    // DEPTH is a power of two, so the top count bit alone marks "full".
    assign full  = count[PW];
    assign empty = (count == '0);

    // A pop in the same cycle never frees space for a push into a full queue.
    assign bus.cpu_ready = reset && !full;
    assign push          = bus.cpu_valid && bus.cpu_ready;
    assign pop           = (state == S_RESP);

    // The cache port always shows the queue head; it is stable while in flight.
    assign head_rw    = fifo_rw[rd_ptr];
    assign bus.rw     = head_rw;
    assign bus.addr   = fifo_addr[rd_ptr];
    assign bus.dataIn = fifo_wdata[rd_ptr];

    assign bus.valid_req = (state == S_ISSUE);
    assign bus.rsp_valid = (state == S_RESP);

    assign timeout     = (ack_timer == TW'(ACK_TIMEOUT));
    assign done_now    = (state == S_WAIT_DONE) && bus.cache_ready;
    assign abandon_now = (state == S_WAIT_ACK) && bus.cache_ready && timeout;

    assign bus.rsp_rw     = rsp_rw_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;

    // Request storage; entries are written on push and never cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rw[wr_ptr]    <= bus.cpu_rw;
            fifo_addr[wr_ptr]  <= bus.cpu_addr;
            fifo_wdata[wr_ptr] <= bus.cpu_wdata;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Sequencer next-state: issue, wait for the cache to take it, wait for done.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (!empty && bus.cache_ready) state_nxt = S_ISSUE;
            S_ISSUE:     state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!bus.cache_ready) state_nxt = S_WAIT_DONE;
                else if (timeout)     state_nxt = S_RESP;
            end
            S_WAIT_DONE: if (bus.cache_ready) state_nxt = S_RESP;
            S_RESP:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Cycles spent in WAIT_ACK; restarts from zero on every entry.
    always_ff @(posedge clk) begin
        if (!reset || state != S_WAIT_ACK) ack_timer <= '0;
        else                               ack_timer <= ack_timer + 1'b1;
    end

    // Sticky hit/miss flags, restarted in ISSUE and sampled up to WAIT_DONE exit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_seen  <= 1'b0;
            miss_seen <= 1'b0;
        end else begin
            case (state)
                S_ISSUE: begin
                    hit_seen  <= bus.hit;
                    miss_seen <= bus.miss;
                end
                S_WAIT_ACK, S_WAIT_DONE: begin
                    hit_seen  <= hit_seen  | bus.hit;
                    miss_seen <= miss_seen | bus.miss;
                end
                default: begin
                    hit_seen  <= hit_seen;
                    miss_seen <= miss_seen;
                end
            endcase
        end
    end

    // Response fields load on entry to RESP and hold until the next one.
    // A miss followed by an allocate-hit still reports as a miss.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_rw_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else if (done_now) begin
            rsp_rw_q   <= head_rw;
            rsp_data_q <= head_rw ? bus.dataOut : 32'h0;
            rsp_hit_q  <= (hit_seen | bus.hit) && !(miss_seen | bus.miss);
            rsp_err_q  <= 1'b0;
        end else if (abandon_now) begin
            rsp_rw_q   <= head_rw;
            rsp_data_q <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_err_q  <= 1'b1;
        end
    end

    // Saturating statistics; abandoned requests count in neither.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == S_RESP && !rsp_err_q) begin
            if (rsp_hit_q && hit_cnt != '1)  hit_cnt  <= hit_cnt + 1'b1;
            if (miss_seen && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_cache_req_queue.sv
// Bench for cache_req_queue: a behavioural direct-mapped cache drives the
// cache port, and a scoreboard predicts each response from the pushed request
// stream using its own tag/memory picture of the cache.
module tb_cache_req_queue;
  localparam int DEPTH       = 4;
  localparam int ACK_TIMEOUT = 16;
  localparam int CNT_W       = 4;
  localparam int MAXC        = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_req_queue_if #(.CNT_W(CNT_W)) bus();

  cache_req_queue #(
    .DEPTH(DEPTH),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- cache model ----------------
  bit          no_ack   = 1'b0;
  bit          hold_low = 1'b0;
  logic        c_v   [8];
  logic [24:0] c_tag [8];
  logic [31:0] c_mem [logic [29:0]];
  int          c_stage;
  int          c_low;
  logic        c_first;
  logic        c_is_hit;
  logic        c_rw;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;

  initial begin
    for (int i = 0; i < 8; i++) begin c_v[i] = 1'b0; c_tag[i] = '0; end
    bus.cache_ready = 1'b1;
    bus.hit = 1'b0;
    bus.miss = 1'b0;
    bus.dataOut = '0;
    c_stage = 0;
    forever begin
      @(posedge clk); #1;
      bus.hit  = 1'b0;
      bus.miss = 1'b0;
      if (reset !== 1'b1) begin
        c_stage = 0;
        bus.cache_ready = 1'b1;
        bus.dataOut = $urandom;
      end else if (c_stage == 0) begin
        bus.cache_ready = !hold_low;
        bus.dataOut = $urandom;
        if (bus.valid_req && !no_ack) begin
          c_rw = bus.rw; c_addr = bus.addr; c_wdata = bus.dataIn;
          c_is_hit = c_v[c_addr[6:4]] && (c_tag[c_addr[6:4]] == c_addr[31:7]);
          c_low = c_is_hit ? int'($urandom_range(1, 2)) : int'($urandom_range(3, 5));
          c_first = 1'b1;
          c_stage = 1;
        end
      end else if (c_stage == 1) begin
        bus.cache_ready = 1'b0;
        bus.dataOut = $urandom;
        if (c_first && !c_is_hit) bus.miss = 1'b1;
        c_first = 1'b0;
        c_low--;
        if (c_low == 0) c_stage = 2;
      end else begin
        // Completion cycle: hit is pulsed for hits and as allocate-hit after misses.
        bus.cache_ready = 1'b1;
        bus.hit = 1'b1;
        c_v[c_addr[6:4]] = 1'b1;
        c_tag[c_addr[6:4]] = c_addr[31:7];
        if (c_rw) bus.dataOut = c_mem.exists(c_addr[31:2]) ? c_mem[c_addr[31:2]] : 32'h0;
        else begin c_mem[c_addr[31:2]] = c_wdata; bus.dataOut = $urandom; end
        c_stage = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [65:0] exp_q[$];          // {no_ack, rw, addr, wdata} in push order
  logic        sb_v   [8];
  logic [24:0] sb_tag [8];
  logic [31:0] sb_mem [logic [29:0]];
  int          sb_hits = 0;
  int          sb_misses = 0;
  bit          cnt_pending = 1'b0;
  logic [65:0] e;
  logic        e_noack, e_rw, x_err, x_hit;
  logic [31:0] e_addr, e_wdata, x_data;
  logic [2:0]  idx;

  initial for (int i = 0; i < 8; i++) begin sb_v[i] = 1'b0; sb_tag[i] = '0; end

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      cnt_pending = 1'b0;
    end else if (bus.rsp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with no outstanding request at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        {e_noack, e_rw, e_addr, e_wdata} = e;
        if (e_noack) begin
          x_err = 1'b1; x_hit = 1'b0; x_data = 32'h0;
        end else begin
          x_err = 1'b0;
          idx = e_addr[6:4];
          x_hit = sb_v[idx] && (sb_tag[idx] == e_addr[31:7]);
          sb_v[idx] = 1'b1;
          sb_tag[idx] = e_addr[31:7];
          if (e_rw) x_data = sb_mem.exists(e_addr[31:2]) ? sb_mem[e_addr[31:2]] : 32'h0;
          else begin sb_mem[e_addr[31:2]] = e_wdata; x_data = 32'h0; end
          if (x_hit) begin if (sb_hits < MAXC) sb_hits++; end
          else if (sb_misses < MAXC) sb_misses++;
        end
        if ({bus.rsp_err, bus.rsp_hit, bus.rsp_rw, bus.rsp_data} !== {x_err, x_hit, e_rw, x_data}) begin
          failures++;
          $display("FAIL rsp_fields addr=%h: got err=%b hit=%b rw=%b data=%h, want err=%b hit=%b rw=%b data=%h",
                   e_addr, bus.rsp_err, bus.rsp_hit, bus.rsp_rw, bus.rsp_data, x_err, x_hit, e_rw, x_data);
        end
        cnt_pending = 1'b1;
      end
    end else if (cnt_pending) begin
      cnt_pending = 1'b0;
      checks++;
      if (bus.hit_count !== CNT_W'(sb_hits) || bus.miss_count !== CNT_W'(sb_misses)) begin
        failures++;
        $display("FAIL counters: got hit=%0d miss=%0d, want hit=%0d miss=%0d",
                 bus.hit_count, bus.miss_count, sb_hits, sb_misses);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_req(input logic rw, input logic [31:0] a, input logic [31:0] d);
    int waited = 0;
    bus.cpu_valid = 1'b1; bus.cpu_rw = rw; bus.cpu_addr = a; bus.cpu_wdata = d;
    @(negedge clk);
    while (bus.cpu_ready !== 1'b1 && waited < 300) begin @(negedge clk); waited++; end
    if (bus.cpu_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL push_timeout: cpu_ready=%b after %0d cycles, want 1", bus.cpu_ready, waited);
    end else begin
      @(posedge clk);
      exp_q.push_back({no_ack, rw, a, d});
    end
    #1;
    bus.cpu_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d responses outstanding, want 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cpu_ready, bus.valid_req, bus.rsp_valid, bus.rsp_rw, bus.rsp_hit, bus.rsp_err} !== 6'b0 ||
        bus.rsp_data !== 32'h0 || bus.hit_count !== '0 || bus.miss_count !== '0) begin
      failures++;
      $display("FAIL reset_values: ready=%b vreq=%b rsp_valid=%b rw=%b hit=%b err=%b data=%h hc=%0d mc=%0d, want all 0",
               bus.cpu_ready, bus.valid_req, bus.rsp_valid, bus.rsp_rw, bus.rsp_hit, bus.rsp_err,
               bus.rsp_data, bus.hit_count, bus.miss_count);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cpu_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %b, want 1", bus.cpu_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_miss_hit();
    push_req(1'b1, 32'h0000_0020, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.valid_req !== 1'b0) begin
      failures++; $display("FAIL latency_early: valid_req=%b in push cycle, want 0", bus.valid_req);
    end
    @(negedge clk);
    checks++;
    if (bus.valid_req !== 1'b1 || bus.addr !== 32'h0000_0020 || bus.rw !== 1'b1) begin
      failures++;
      $display("FAIL latency_issue: valid_req=%b addr=%h rw=%b, want 1 00000020 1", bus.valid_req, bus.addr, bus.rw);
    end
    @(negedge clk);
    checks++;
    if (bus.valid_req !== 1'b0) begin
      failures++; $display("FAIL strobe_width: valid_req=%b one cycle after issue, want 0", bus.valid_req);
    end
    @(posedge clk); #1;
    push_req(1'b1, 32'h0000_0040, 32'h0);
    push_req(1'b1, 32'h0000_0020, 32'h0);
    wait_drain();
    checks++;
    if (bus.hit_count !== CNT_W'(1) || bus.miss_count !== CNT_W'(2)) begin
      failures++;
      $display("FAIL miss_hit_counts: got hit=%0d miss=%0d, want hit=1 miss=2", bus.hit_count, bus.miss_count);
    end
  endtask

  task automatic test_write_read();
    push_req(1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    push_req(1'b1, 32'h0000_0100, 32'h0);
    wait_drain();
    checks++;
    if (bus.rsp_rw !== 1'b1 || bus.rsp_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL write_read: rsp_rw=%b rsp_data=%h, want 1 deadbeef", bus.rsp_rw, bus.rsp_data);
    end
  endtask

  task automatic test_full();
    int n = 0;
    int bad = 0;
    hold_low = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < DEPTH; i++) push_req(1'b0, 32'h0000_0180 + 32'(i * 4), $urandom);
    @(negedge clk);
    checks++;
    if (bus.cpu_ready !== 1'b0) begin
      failures++; $display("FAIL full_ready: cpu_ready=%b after %0d pushes, want 0", bus.cpu_ready, DEPTH);
    end
    bus.cpu_valid = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 32'h0000_01F0; bus.cpu_wdata = 32'h5555_AAAA;
    repeat (3) begin @(negedge clk); if (bus.cpu_ready !== 1'b0) bad++; end
    @(posedge clk); #1;
    bus.cpu_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL full_reject: cpu_ready high in %0d of 3 cycles, want 0", bad);
    end
    hold_low = 1'b0;
    @(negedge clk);
    while (bus.rsp_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.cpu_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_resp_cycle: rsp_valid=%b cpu_ready=%b, want 1 0", bus.rsp_valid, bus.cpu_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.cpu_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_pop: cpu_ready=%b, want 1", bus.cpu_ready);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_timeout();
    int n = 0;
    int cyc = 0;
    logic [CNT_W-1:0] hc0, mc0;
    hc0 = bus.hit_count;
    mc0 = bus.miss_count;
    no_ack = 1'b1;
    push_req(1'b1, 32'h0000_0200, 32'h0);
    @(negedge clk);
    while (bus.valid_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    while (bus.rsp_valid !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != ACK_TIMEOUT + 2 || bus.rsp_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_latency: rsp after %0d cycles err=%b, want %0d err=1", cyc, bus.rsp_err, ACK_TIMEOUT + 2);
    end
    no_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.hit_count !== hc0 || bus.miss_count !== mc0) begin
      failures++;
      $display("FAIL timeout_counts: got hit=%0d miss=%0d, want hit=%0d miss=%0d", bus.hit_count, bus.miss_count, hc0, mc0);
    end
    @(posedge clk); #1;
    push_req(1'b1, 32'h0000_0200, 32'h0);
    n = 0;
    while (bus.valid_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (bus.valid_req !== 1'b1) begin
      failures++; $display("FAIL issue_after_timeout: valid_req=%b within 10 cycles, want 1", bus.valid_req);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    int n = 0;
    int seen = 0;
    push_req(1'b1, 32'h0000_0400, 32'h0);
    push_req(1'b1, 32'h0000_0480, 32'h0);
    push_req(1'b1, 32'h0000_0500, 32'h0);
    @(negedge clk);
    while (bus.cache_ready !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    sb_hits = 0;
    sb_misses = 0;
    @(negedge clk);
    checks++;
    if (bus.cpu_ready !== 1'b0 || bus.valid_req !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.hit_count !== '0 || bus.miss_count !== '0) begin
      failures++;
      $display("FAIL midflight_reset: ready=%b vreq=%b rsp_valid=%b hc=%0d mc=%0d, want all 0",
               bus.cpu_ready, bus.valid_req, bus.rsp_valid, bus.hit_count, bus.miss_count);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.valid_req !== 1'b0 || bus.rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || bus.cpu_ready !== 1'b1) begin
      failures++;
      $display("FAIL stale_after_reset: %0d active cycles cpu_ready=%b, want 0 cycles ready=1", seen, bus.cpu_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = (32'($urandom_range(0, 31)) << 4) | (32'($urandom_range(0, 3)) << 2);
      push_req(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_drain();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 18; i++) push_req(1'b1, 32'h0000_0300, 32'h0);
    wait_drain();
    checks++;
    if (bus.hit_count !== CNT_W'(MAXC)) begin
      failures++; $display("FAIL hit_saturation: hit_count=%0d, want %0d", bus.hit_count, MAXC);
    end
  endtask

  initial begin
    bus.cpu_valid = 1'b0;
    bus.cpu_rw    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    test_reset();
    test_miss_hit();
    test_write_read();
    test_full();
    test_timeout();
    test_reset_midflight();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete by %0t", $time);
    $fatal(1, "bench timeout");
  end
endmodule
